// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad digit-entry block.
//  - KEYMAP[r][c]  : 4-bit key code for row r / column c of the 4x4 matrix
//  - KEY_BACKSPACE : code that removes the newest digit
//  - DIGIT_EMPTY   : value shown in an unfilled entry slot
//  - scan_state_e  : debounce FSM states
//  - helpers for one-cold decode and column rotation
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } scan_state_e;

  localparam logic [3:0] KEY_BACKSPACE = 4'hA;
  localparam logic [4:0] DIGIT_EMPTY   = 5'h1F;

  // Packed so that KEYMAP[r][c] selects a code; the rightmost entry is index 0.
  //   Row 0: 1 2 3 A   Row 1: 4 5 6 B   Row 2: 7 8 9 C   Row 3: E 0 F D
  localparam logic [3:0][3:0][3:0] KEYMAP = {
    {4'hD, 4'hF, 4'h0, 4'hE},
    {4'hC, 4'h9, 4'h8, 4'h7},
    {4'hB, 4'h6, 4'h5, 4'h4},
    {4'hA, 4'h3, 4'h2, 4'h1}
  };

  // True when exactly one bit of an active-low vector is asserted.
  function automatic logic is_single_low(input logic [3:0] v);
    logic res;
    case (v)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: res = 1'b1;
      default:                            res = 1'b0;
    endcase
    return res;
  endfunction

  // Position of the single 0 bit; only meaningful for one-cold input.
  function automatic logic [1:0] onecold_index(input logic [3:0] v);
    logic [1:0] res;
    case (v)
      4'b1110: res = 2'd0;
      4'b1101: res = 2'd1;
      4'b1011: res = 2'd2;
      4'b0111: res = 2'd3;
      default: res = 2'd0;
    endcase
    return res;
  endfunction

  // Next column drive. Any corrupted pattern falls back to column 0.
  function automatic logic [3:0] next_col(input logic [3:0] c);
    logic [3:0] res;
    case (c)
      4'b1110: res = 4'b1101;
      4'b1101: res = 4'b1011;
      4'b1011: res = 4'b0111;
      default: res = 4'b1110;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/keypad_scan_fsm.sv
// Column scanner and debouncer for a 4x4 active-low keypad.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   row   [3:0]  in   raw keypad rows (active-low, asynchronous to clk)
//   col   [3:0]  out  one-cold column drive (registered)
//   accept       out  high for the single cycle whose closing edge accepts a key
//   key_row [1:0] out row of the key being debounced / accepted
//   key_col [1:0] out column of the key being debounced / accepted
// accept is decoded from registers only, so the consumer registers it once
// and the press shows up one clock after the accepting sample.
module keypad_scan_fsm
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV         = 50000,
  parameter int DEBOUNCE_SAMPLES = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       accept,
  output logic [1:0] key_row,
  output logic [1:0] key_col
);

  localparam int TW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_TARGET = DW'(DEBOUNCE_SAMPLES);

  logic [3:0]    row_meta_q, row_sync_q;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    col_q, col_d;
  scan_state_e   state_q, state_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [1:0]    key_row_q, key_row_d;
  logic [1:0]    key_col_q, key_col_d;
  logic          accept_s;

  logic          sample_s, single_s, idle_s;
  logic [DW-1:0] deb_inc_s;

  assign sample_s  = (timer_q == TIMER_LAST);
  assign single_s  = is_single_low(row_sync_q);
  assign idle_s    = (row_sync_q == 4'hF);
  assign deb_inc_s = deb_cnt_q + DW'(1);

  // Row synchronizer, slot timer and FSM state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
      timer_q    <= '0;
      col_q      <= 4'b1110;
      state_q    <= SCAN;
      deb_cnt_q  <= '0;
      key_row_q  <= 2'd0;
      key_col_q  <= 2'd0;
    end else begin
      row_meta_q <= row;
      row_sync_q <= row_meta_q;
      timer_q    <= timer_d;
      col_q      <= col_d;
      state_q    <= state_d;
      deb_cnt_q  <= deb_cnt_d;
      key_row_q  <= key_row_d;
      key_col_q  <= key_col_d;
    end
  end

  // Slot timer wraps on the sampling cycle.
  always_comb begin
    timer_d = timer_q + TW'(1);
    if (sample_s) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end
  end

  // Debounce FSM: all decisions are taken on the sampling cycle only.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    deb_cnt_d = deb_cnt_q;
    key_row_d = key_row_q;
    key_col_d = key_col_q;
    accept_s  = 1'b0;
    case (state_q)
      SCAN: begin
        if (sample_s) begin
          if (single_s) begin
            key_row_d = onecold_index(row_sync_q);
            key_col_d = onecold_index(col_q);
            deb_cnt_d = DW'(1);
            state_d   = DEBOUNCE;
          end else begin
            col_d = next_col(col_q);
          end
        end else begin
          state_d = SCAN;
        end
      end
      DEBOUNCE: begin
        if (sample_s) begin
          if (single_s && (onecold_index(row_sync_q) == key_row_q)) begin
            if (deb_inc_s == DEB_TARGET) begin
              accept_s  = 1'b1;
              deb_cnt_d = '0;
              state_d   = HELD;
            end else begin
              deb_cnt_d = deb_inc_s;
            end
          end else begin
            // Bounce or a different key: resume scanning past this column.
            deb_cnt_d = '0;
            col_d     = next_col(col_q);
            state_d   = SCAN;
          end
        end else begin
          state_d = DEBOUNCE;
        end
      end
      HELD: begin
        if (sample_s) begin
          if (idle_s) begin
            if (deb_inc_s == DEB_TARGET) begin
              deb_cnt_d = '0;
              col_d     = next_col(col_q);
              state_d   = SCAN;
            end else begin
              deb_cnt_d = deb_inc_s;
            end
          end else begin
            // Release must be seen on consecutive samples.
            deb_cnt_d = '0;
          end
        end else begin
          state_d = HELD;
        end
      end
      default: begin
        state_d   = SCAN;
        deb_cnt_d = '0;
        col_d     = 4'b1110;
      end
    endcase
  end

  assign col     = col_q;
  assign accept  = accept_s;
  assign key_row = key_row_q;
  assign key_col = key_col_q;

endmodule

// File: rtl/keypad_digit_entry.sv
// Keypad front end for the safe-box controller: scans and debounces a 4x4
// keypad and keeps a rolling 4-digit entry buffer.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   row   [3:0]   in    keypad rows, active-low, pulled up
//   col   [3:0]   out   keypad column drive, one-cold active-low
//   clr           in    synchronous buffer clear (1-cycle pulse, beats a same-cycle digit)
//   p0..p3 [4:0]  out   entry digits, p0 newest; 5'h1F marks an empty slot
//   digit_count   out   filled slots, 0..4
//   key_valid     out   1-cycle pulse per accepted key (any key, also during clr)
//   key_code [3:0] out  code of the last accepted key, held until the next one
module keypad_digit_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV         = 50000,
  parameter int DEBOUNCE_SAMPLES = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  input  logic       clr,
  output logic [4:0] p0,
  output logic [4:0] p1,
  output logic [4:0] p2,
  output logic [4:0] p3,
  output logic [2:0] digit_count,
  output logic       key_valid,
  output logic [3:0] key_code
);

  logic       accept_s;
  logic [1:0] key_row_s, key_col_s;
  logic [3:0] code_s;

  // Index 0 is p0 (newest digit).
  logic [3:0][4:0] buf_q, buf_d;
  logic [2:0]      count_q, count_d;
  logic            key_valid_q, key_valid_d;
  logic [3:0]      key_code_q, key_code_d;

  keypad_scan_fsm #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
  ) u_scan (
    .clk    (clk),
    .rst    (rst),
    .row    (row),
    .col    (col),
    .accept (accept_s),
    .key_row(key_row_s),
    .key_col(key_col_s)
  );

  assign code_s = KEYMAP[key_row_s][key_col_s];

  // Entry buffer and key report registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q       <= {4{DIGIT_EMPTY}};
      count_q     <= 3'd0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
    end else begin
      buf_q       <= buf_d;
      count_q     <= count_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
    end
  end

  // Key report plus buffer update; clr has priority over an accepted key.
  always_comb begin
    buf_d       = buf_q;
    count_d     = count_q;
    key_valid_d = accept_s;
    key_code_d  = key_code_q;
    if (accept_s) begin
      key_code_d = code_s;
    end else begin
      key_code_d = key_code_q;
    end
    if (clr) begin
      buf_d   = {4{DIGIT_EMPTY}};
      count_d = 3'd0;
    end else if (accept_s) begin
      if (code_s <= 4'd9) begin
        // Shift in; the oldest digit falls off the end when full.
        buf_d   = {buf_q[2], buf_q[1], buf_q[0], {1'b0, code_s}};
        count_d = (count_q == 3'd4) ? 3'd4 : (count_q + 3'd1);
      end else if (code_s == KEY_BACKSPACE) begin
        if (count_q != 3'd0) begin
          buf_d   = {DIGIT_EMPTY, buf_q[3], buf_q[2], buf_q[1]};
          count_d = count_q - 3'd1;
        end else begin
          buf_d   = buf_q;
          count_d = count_q;
        end
      end else begin
        // Function keys are only reported.
        buf_d   = buf_q;
        count_d = count_q;
      end
    end else begin
      buf_d   = buf_q;
      count_d = count_q;
    end
  end

  assign p0          = buf_q[0];
  assign p1          = buf_q[1];
  assign p2          = buf_q[2];
  assign p3          = buf_q[3];
  assign digit_count = count_q;
  assign key_valid   = key_valid_q;
  assign key_code    = key_code_q;

endmodule

// File: tb/tb_keypad_digit_entry.sv
// Self-checking bench for keypad_digit_entry with SCAN_DIV=4, DEBOUNCE_SAMPLES=3.
// A keypad model turns pressed keys into row levels from the column drive.
// Each press pushes the expected code and buffer into a scoreboard queue;
// a monitor pops and compares whenever key_valid pulses.
module tb_keypad_digit_entry;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row;
  logic [3:0] col;
  logic       clr = 1'b0;
  logic [4:0] p0, p1, p2, p3;
  logic [2:0] digit_count;
  logic       key_valid;
  logic [3:0] key_code;

  // keys[r][c] = 1 while the key at row r / column c is held down.
  logic [3:0][3:0] keys = '0;

  typedef struct packed {
    logic [3:0] code;
    logic [4:0] b0;
    logic [4:0] b1;
    logic [4:0] b2;
    logic [4:0] b3;
    logic [2:0] cnt;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [4:0] m_buf[4];
  logic [2:0] m_cnt;
  int         checks = 0;
  int         errors = 0;

  keypad_digit_entry #(
    .SCAN_DIV        (4),
    .DEBOUNCE_SAMPLES(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .row        (row),
    .col        (col),
    .clr        (clr),
    .p0         (p0),
    .p1         (p1),
    .p2         (p2),
    .p3         (p3),
    .digit_count(digit_count),
    .key_valid  (key_valid),
    .key_code   (key_code)
  );

  always #5 clk = ~clk;

  // Passive keypad: a row reads low when a held key sits in the driven column.
  always_comb begin
    for (int r = 0; r < 4; r++) row[r] = ~|(keys[r] & ~col);
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst && key_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse key_code=%h, required no key_valid", key_code);
      end else begin
        mon_e = exp_q.pop_front();
        if (key_code !== mon_e.code || p0 !== mon_e.b0 || p1 !== mon_e.b1 ||
            p2 !== mon_e.b2 || p3 !== mon_e.b3 || digit_count !== mon_e.cnt) begin
          errors++;
          $display("FAIL pulse got code=%h p=%h,%h,%h,%h cnt=%0d required code=%h p=%h,%h,%h,%h cnt=%0d",
                   key_code, p0, p1, p2, p3, digit_count,
                   mon_e.code, mon_e.b0, mon_e.b1, mon_e.b2, mon_e.b3, mon_e.cnt);
        end
      end
    end
  end

  function automatic logic [3:0] code_of(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_buf[i] = 5'h1F;
    m_cnt = 3'd0;
  endtask

  task automatic model_key(input logic [3:0] code, input bit with_clr);
    if (with_clr) begin
      model_reset();
    end else if (code <= 4'd9) begin
      m_buf[3] = m_buf[2];
      m_buf[2] = m_buf[1];
      m_buf[1] = m_buf[0];
      m_buf[0] = {1'b0, code};
      if (m_cnt < 3'd4) m_cnt = m_cnt + 3'd1;
    end else if (code == 4'hA && m_cnt != 3'd0) begin
      m_buf[0] = m_buf[1];
      m_buf[1] = m_buf[2];
      m_buf[2] = m_buf[3];
      m_buf[3] = 5'h1F;
      m_cnt    = m_cnt - 3'd1;
    end
  endtask

  task automatic push_expect(input logic [3:0] code);
    exp_t e;
    e.code = code;
    e.b0 = m_buf[0]; e.b1 = m_buf[1]; e.b2 = m_buf[2]; e.b3 = m_buf[3];
    e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  // Returns one ns after the clock edge on which col switches to target.
  task automatic wait_col(input logic [3:0] target);
    logic [3:0] prev;
    bit found;
    found = 1'b0;
    prev  = col;
    for (int n = 0; n < 64 && !found; n++) begin
      @(posedge clk);
      #1;
      if (col == target && prev != target) found = 1'b1;
      prev = col;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_col col=%b, required a switch to %b within 64 cycles", col, target);
    end
  endtask

  // Press a key, wait for its pulse, hold, release, let the FSM return to SCAN.
  task automatic press_key(input logic [1:0] r, input logic [1:0] c, input int hold_cycles);
    int n;
    model_key(code_of(r, c), 1'b0);
    push_expect(code_of(r, c));
    keys[r][c] = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL press_timeout pending=%0d key=%h, required 0 pending", exp_q.size(), code_of(r, c));
      exp_q.delete();
    end
    repeat (hold_cycles) @(posedge clk);
    keys[r][c] = 1'b0;
    repeat (40) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (col !== 4'b1110 || p0 !== 5'h1F || p1 !== 5'h1F || p2 !== 5'h1F || p3 !== 5'h1F ||
        digit_count !== 3'd0 || key_valid !== 1'b0 || key_code !== 4'h0) begin
      errors++;
      $display("FAIL reset_values col=%b p=%h,%h,%h,%h cnt=%0d kv=%b kc=%h required 1110 1F,1F,1F,1F 0 0 0",
               col, p0, p1, p2, p3, digit_count, key_valid, key_code);
    end
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_single_press();
    // Key '2' held for 20 further samples: the monitor flags any extra pulse.
    press_key(2'd0, 2'd1, 80);
    checks++;
    if (key_code !== 4'h2 || p0 !== 5'h02 || digit_count !== 3'd1) begin
      errors++;
      $display("FAIL single_press kc=%h p0=%h cnt=%0d required 2 02 1", key_code, p0, digit_count);
    end
  endtask

  task automatic test_bounce();
    int n;
    bit seen;
    wait_col(4'b1101);
    keys[0][1] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    keys[0][1] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    keys[0][1] = 1'b1;
    model_key(4'h2, 1'b0);
    push_expect(4'h2);
    wait_col(4'b1101);
    n = 0;
    seen = 1'b0;
    while (n < 40 && !seen) begin
      @(posedge clk);
      #1;
      n++;
      if (key_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || n != 12) begin
      errors++;
      $display("FAIL bounce_latency seen=%b cycles=%0d required pulse after 12 cycles", seen, n);
    end
    repeat (20) @(posedge clk);
    keys[0][1] = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bounce_pending pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_entry();
    press_key(2'd0, 2'd0, 4);
    press_key(2'd0, 2'd1, 4);
    press_key(2'd0, 2'd2, 4);
    press_key(2'd1, 2'd0, 4);
    press_key(2'd1, 2'd1, 4);
    checks++;
    if (p0 !== 5'h05 || p1 !== 5'h04 || p2 !== 5'h03 || p3 !== 5'h02 || digit_count !== 3'd4) begin
      errors++;
      $display("FAIL entry_full p=%h,%h,%h,%h cnt=%0d required 05,04,03,02 4", p0, p1, p2, p3, digit_count);
    end
    press_key(2'd0, 2'd3, 4);
    checks++;
    if (p0 !== 5'h04 || p1 !== 5'h03 || p2 !== 5'h02 || p3 !== 5'h1F || digit_count !== 3'd3) begin
      errors++;
      $display("FAIL entry_backspace p=%h,%h,%h,%h cnt=%0d required 04,03,02,1F 3", p0, p1, p2, p3, digit_count);
    end
  endtask

  task automatic test_clear_accept();
    wait_col(4'b1110);
    keys[2][0] = 1'b1;
    model_key(4'h7, 1'b1);
    push_expect(4'h7);
    // Accept lands on the third sample of column 0: the edge 12 cycles on.
    repeat (11) @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    checks++;
    if (key_valid !== 1'b1 || key_code !== 4'h7 || p0 !== 5'h1F || p1 !== 5'h1F ||
        p2 !== 5'h1F || p3 !== 5'h1F || digit_count !== 3'd0) begin
      errors++;
      $display("FAIL clear_accept kv=%b kc=%h p=%h,%h,%h,%h cnt=%0d required 1 7 1F,1F,1F,1F 0",
               key_valid, key_code, p0, p1, p2, p3, digit_count);
    end
    repeat (40) @(posedge clk);
    keys[2][0] = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL clear_accept_pending pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_empty_keys();
    press_key(2'd0, 2'd3, 4);
    press_key(2'd1, 2'd3, 4);
    checks++;
    if (key_code !== 4'hB || p0 !== 5'h1F || p3 !== 5'h1F || digit_count !== 3'd0) begin
      errors++;
      $display("FAIL empty_keys kc=%h p0=%h p3=%h cnt=%0d required B 1F 1F 0", key_code, p0, p3, digit_count);
    end
  endtask

  task automatic test_multi_row();
    logic [3:0] prev;
    int changes;
    keys[0][2] = 1'b1;
    keys[1][2] = 1'b1;
    @(posedge clk);
    #1;
    prev = col;
    changes = 0;
    repeat (48) begin
      @(posedge clk);
      #1;
      if (col != prev) changes++;
      prev = col;
    end
    checks++;
    if (changes != 12) begin
      errors++;
      $display("FAIL multi_row col_changes=%0d required 12", changes);
    end
    keys[0][2] = 1'b0;
    keys[1][2] = 1'b0;
    repeat (20) @(posedge clk);
  endtask

  task automatic test_reset_mid_run();
    int n;
    model_key(4'h9, 1'b0);
    push_expect(4'h9);
    keys[2][2] = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || p0 !== 5'h09) begin
      errors++;
      $display("FAIL mid_run_setup pending=%0d p0=%h required 0 09", exp_q.size(), p0);
      exp_q.delete();
    end
    repeat (8) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (col !== 4'b1110 || p0 !== 5'h1F || p1 !== 5'h1F || p2 !== 5'h1F || p3 !== 5'h1F ||
        digit_count !== 3'd0 || key_valid !== 1'b0 || key_code !== 4'h0) begin
      errors++;
      $display("FAIL async_reset col=%b p=%h,%h,%h,%h cnt=%0d kv=%b kc=%h required 1110 1F,1F,1F,1F 0 0 0",
               col, p0, p1, p2, p3, digit_count, key_valid, key_code);
    end
    keys[2][2] = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_entry();
    test_clear_accept();
    test_empty_keys();
    test_multi_row();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
